// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 decoder between 8 requesters.
// A grant is held while its request stays high. Every release is followed
// by DEAD_CYCLES clocks with the decoder disabled, so two decoder outputs
// are never active back to back. All outputs are registered.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a grant held for MAX_HOLD cycles is forcibly released and
//               oTimeout pulses for one cycle
//   undefined : grants are held indefinitely, oTimeout is constant 0
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | decoder disabled, scanning iReq from ptr+1 for the next winner
// GRANT | decoder enabled on oSel, held while iReq[oSel] stays high
// DEAD  | decoder disabled for DEAD_CYCLES clocks, requests not sampled

module decoder_rr_arbiter #(
   parameter int DEAD_CYCLES = 1,
   parameter int MAX_HOLD    = 16
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [7:0] iReq,
   output logic [2:0] oSel,
   output logic [1:0] oEna,
   output logic [7:0] oGrant,
   output logic       oBusy,
   output logic       oTimeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DEAD  = 2'd2
   } arbStateT;

   localparam logic [1:0] EnaOn    = 2'b10;
   localparam logic [1:0] EnaOff   = 2'b00;
   localparam logic [3:0] DeadLoad = 4'(DEAD_CYCLES - 1);

   // Out-of-range parameters stop elaboration rather than build a broken timer.
   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : gBadDeadCycles
      $error("decoder_rr_arbiter: DEAD_CYCLES must be 1..15");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : gBadMaxHold
      $error("decoder_rr_arbiter: MAX_HOLD must be 1..255");
   end

   arbStateT   state;
   arbStateT   stateNxt;
   logic [2:0] ptr;
   logic [2:0] ptrNxt;
   logic [3:0] deadCnt;
   logic [3:0] deadCntNxt;
   logic [2:0] selNxt;
   logic [1:0] enaNxt;
   logic [7:0] grantNxt;
   logic       busyNxt;
   logic       timeoutNxt;
   logic [2:0] winner;
   logic [2:0] scanIdx;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   logic [7:0] holdCnt;
   logic [7:0] holdCntNxt;
`endif

   // Winner scan: ptr+1 has top priority, ptr itself is checked last so a
   // lone re-requesting holder is still served after its dead time.
   always_comb begin
      winner  = ptr;
      scanIdx = ptr;
      for (int i = 8; i >= 1; i--) begin
         scanIdx = ptr + 3'(i);
         if (iReq[scanIdx]) begin
            winner = scanIdx;
         end
      end
   end

   // Next-state and next-output decode; every register holds by default.
   always_comb begin
      stateNxt   = state;
      ptrNxt     = ptr;
      deadCntNxt = deadCnt;
      selNxt     = oSel;
      enaNxt     = oEna;
      grantNxt   = oGrant;
      busyNxt    = oBusy;
      timeoutNxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
      holdCntNxt = holdCnt;
`endif

      case (state)
         IDLE: begin
            if (|iReq) begin
               stateNxt = GRANT;
               selNxt   = winner;
               grantNxt = 8'd1 << winner;
               enaNxt   = EnaOn;
               busyNxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
               holdCntNxt = 8'd0;
`endif
            end
         end

         GRANT: begin
            if (!iReq[oSel]) begin
               stateNxt   = DEAD;
               ptrNxt     = oSel;
               grantNxt   = 8'h00;
               enaNxt     = EnaOff;
               busyNxt    = 1'b0;
               deadCntNxt = DeadLoad;
`ifdef ARB_TIMEOUT_EN
            end else if (holdCnt == HoldLast) begin
               // Forced release; a voluntary release above wins on the same edge.
               stateNxt   = DEAD;
               ptrNxt     = oSel;
               grantNxt   = 8'h00;
               enaNxt     = EnaOff;
               busyNxt    = 1'b0;
               deadCntNxt = DeadLoad;
               timeoutNxt = 1'b1;
            end else begin
               holdCntNxt = holdCnt + 8'd1;
`endif
            end
         end

         DEAD: begin
            if (deadCnt == 4'd0) begin
               stateNxt = IDLE;
            end else begin
               deadCntNxt = deadCnt - 4'd1;
            end
         end

         default: begin
            stateNxt = IDLE;
            grantNxt = 8'h00;
            enaNxt   = EnaOff;
            busyNxt  = 1'b0;
         end
      endcase
   end

   // State, pointer, timers and registered outputs; reset overrides everything.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= IDLE;
         ptr      <= 3'd7;
         deadCnt  <= 4'd0;
         oSel     <= 3'd0;
         oEna     <= EnaOff;
         oGrant   <= 8'h00;
         oBusy    <= 1'b0;
         oTimeout <= 1'b0;
      end else begin
         state    <= stateNxt;
         ptr      <= ptrNxt;
         deadCnt  <= deadCntNxt;
         oSel     <= selNxt;
         oEna     <= enaNxt;
         oGrant   <= grantNxt;
         oBusy    <= busyNxt;
         oTimeout <= timeoutNxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter: cleared on each new grant, advanced once per GRANT cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         holdCnt <= 8'd0;
      end else begin
         holdCnt <= holdCntNxt;
      end
   end
`endif

endmodule
